// File: rtl/spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_loader
// Purpose  : Autonomous SPI flash READ (0x03) engine. Drives the SPI master's
//            register port as a bus master, streams byte_len bytes out of the
//            flash and packs them little-endian into 32-bit memory writes.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            start/flash_addr/dst_addr/byte_len - job request (sampled on start)
//            busy/done/error             - job status
//            spi_req_* / spi_rdata       - SPI controller register port
//            mem_* / mem_ready           - destination word-write port
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_loader #(
  parameter logic [31:0] SPI_BASE = 32'h0000_0000,
  parameter logic [2:0]  CLK_DIV  = 3'd2,
  parameter logic [15:0] POLL_MAX = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] byte_len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        spi_req_valid,
  output logic        spi_req_write,
  output logic [31:0] spi_req_addr,
  output logic [31:0] spi_req_wdata,
  output logic [3:0]  spi_req_wstrb,
  input  logic [31:0] spi_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready
);

  localparam logic [31:0] c_ofs_ctrl   = 32'h0000_0000;
  localparam logic [31:0] c_ofs_status = 32'h0000_0004;
  localparam logic [31:0] c_ofs_txdata = 32'h0000_0008;
  localparam logic [31:0] c_ofs_rxdata = 32'h0000_000C;
  // bit8 = cs_force, bits[3:1] = clock divide, bit0 = enable
  localparam logic [31:0] c_ctrl_cs_on  = 32'h0000_0100 | {28'h0, CLK_DIV, 1'b1};
  localparam logic [31:0] c_ctrl_cs_off = {28'h0, CLK_DIV, 1'b1};

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CS_ON  = 4'd1,
    TX_WR  = 4'd2,
    TX_GAP = 4'd3,
    POLL   = 4'd4,
    RX_RD  = 4'd5,
    MEM_WR = 4'd6,
    CS_OFF = 4'd7,
    FIN    = 4'd8
  } state_t;

  state_t      r_state, w_next;
  logic [23:0] r_faddr;
  logic [15:0] r_len;
  logic [15:0] r_byte_cnt;   // data bytes received so far
  logic [2:0]  r_hdr_cnt;    // header bytes received so far (0..4)
  logic [15:0] r_poll_cnt;
  logic        r_error;
  logic [31:0] r_mem_addr;
  logic [31:0] r_pack;
  logic [3:0]  r_strb;

  logic        w_hdr;
  logic [1:0]  w_lane;
  logic        w_last;
  logic        w_rx_ready;
  logic        w_poll_last;
  logic [7:0]  w_tx_byte;
  logic        w_unused_bits;

  assign w_hdr       = ~r_hdr_cnt[2];
  assign w_lane      = r_byte_cnt[1:0];
  assign w_last      = (r_byte_cnt + 16'd1) == r_len;
  assign w_rx_ready  = ~spi_rdata[0] & spi_rdata[1];
  assign w_poll_last = (r_poll_cnt + 16'd1) == POLL_MAX;
  // Only the low RX byte and the word-aligned destination bits are meaningful.
  assign w_unused_bits = ^{spi_rdata[31:8], dst_addr[1:0]};

  // Header bytes are sent while the header RX count is below 4; after that,
  // dummy zero bytes clock the data out. Only one byte is ever in flight, so
  // the RX count doubles as the TX index.
  always_comb begin
    w_tx_byte = 8'h00;
    if (w_hdr) begin
      case (r_hdr_cnt[1:0])
        2'd0:    w_tx_byte = 8'h03;
        2'd1:    w_tx_byte = r_faddr[23:16];
        2'd2:    w_tx_byte = r_faddr[15:8];
        default: w_tx_byte = r_faddr[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    spi_req_valid = 1'b0;
    spi_req_write = 1'b0;
    spi_req_addr  = SPI_BASE;
    spi_req_wdata = 32'h0;
    mem_valid     = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (byte_len == 16'd0) ? FIN : CS_ON;
      end
      CS_ON: begin
        spi_req_valid = 1'b1;
        spi_req_write = 1'b1;
        spi_req_addr  = SPI_BASE + c_ofs_ctrl;
        spi_req_wdata = c_ctrl_cs_on;
        w_next        = TX_WR;
      end
      TX_WR: begin
        spi_req_valid = 1'b1;
        spi_req_write = 1'b1;
        spi_req_addr  = SPI_BASE + c_ofs_txdata;
        spi_req_wdata = {24'h0, w_tx_byte};
        w_next        = TX_GAP;
      end
      // The controller's busy flag lags the TXDATA write by one cycle.
      TX_GAP: w_next = POLL;
      POLL: begin
        spi_req_valid = 1'b1;
        spi_req_addr  = SPI_BASE + c_ofs_status;
        if (w_rx_ready)       w_next = RX_RD;
        else if (w_poll_last) w_next = CS_OFF;
      end
      RX_RD: begin
        spi_req_valid = 1'b1;
        spi_req_addr  = SPI_BASE + c_ofs_rxdata;
        if (w_hdr)                            w_next = TX_WR;
        else if ((w_lane == 2'd3) || w_last)  w_next = MEM_WR;
        else                                  w_next = TX_WR;
      end
      MEM_WR: begin
        mem_valid = 1'b1;
        if (mem_ready) w_next = (r_byte_cnt == r_len) ? CS_OFF : TX_WR;
      end
      CS_OFF: begin
        spi_req_valid = 1'b1;
        spi_req_write = 1'b1;
        spi_req_addr  = SPI_BASE + c_ofs_ctrl;
        spi_req_wdata = c_ctrl_cs_off;
        w_next        = FIN;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_faddr    <= 24'h0;
      r_len      <= 16'h0;
      r_byte_cnt <= 16'h0;
      r_hdr_cnt  <= 3'h0;
      r_poll_cnt <= 16'h0;
      r_error    <= 1'b0;
      r_mem_addr <= 32'h0;
      r_pack     <= 32'h0;
      r_strb     <= 4'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_faddr    <= flash_addr;
            r_len      <= byte_len;
            r_byte_cnt <= 16'h0;
            r_hdr_cnt  <= 3'h0;
            r_error    <= 1'b0;
            r_mem_addr <= {dst_addr[31:2], 2'b00};
            r_pack     <= 32'h0;
            r_strb     <= 4'h0;
          end
        end
        TX_GAP: r_poll_cnt <= 16'h0;
        POLL: begin
          if (!w_rx_ready) begin
            r_poll_cnt <= r_poll_cnt + 16'd1;
            if (w_poll_last) r_error <= 1'b1;
          end
        end
        RX_RD: begin
          if (w_hdr) begin
            r_hdr_cnt <= r_hdr_cnt + 3'd1;
          end else begin
            r_pack[{w_lane, 3'b000} +: 8] <= spi_rdata[7:0];
            r_strb[w_lane]                <= 1'b1;
            r_byte_cnt                    <= r_byte_cnt + 16'd1;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            r_mem_addr <= r_mem_addr + 32'd4;
            r_pack     <= 32'h0;
            r_strb     <= 4'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign error         = r_error;
  assign spi_req_wstrb = 4'hF;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_pack;
  assign mem_wstrb     = r_strb;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_loader
// Purpose  : Directed self-checking bench for spi_flash_loader with a small
//            SPI controller / flash model and a memory-port capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_loader;

  localparam logic [31:0] c_base     = 32'h4000_0000;
  localparam logic [31:0] c_ctrl_on  = 32'h0000_0105;
  localparam logic [31:0] c_ctrl_off = 32'h0000_0005;
  localparam int          c_shift    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_addr = 24'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] byte_len = 16'h0;
  logic        busy, done, error;
  logic        spi_req_valid, spi_req_write;
  logic [31:0] spi_req_addr, spi_req_wdata;
  logic [3:0]  spi_req_wstrb;
  logic [31:0] spi_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1;
  logic        stuck = 1'b0;

  spi_flash_loader #(
    .SPI_BASE(c_base),
    .CLK_DIV (3'd2),
    .POLL_MAX(16'd16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flash_addr   (flash_addr),
    .dst_addr     (dst_addr),
    .byte_len     (byte_len),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .spi_req_valid(spi_req_valid),
    .spi_req_write(spi_req_write),
    .spi_req_addr (spi_req_addr),
    .spi_req_wdata(spi_req_wdata),
    .spi_req_wstrb(spi_req_wstrb),
    .spi_rdata    (spi_rdata),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- SPI controller + flash model ----------------
  logic       m_pend, m_busy, m_rxv;
  logic [7:0] m_rx, m_rx_next;
  int         m_cnt, m_idx;
  logic [31:0] last_ctrl;
  logic [7:0] mosi_q[$];
  int n_spi = 0, n_status = 0, n_tx_busy = 0, n_tx_in_mem = 0;

  always_comb begin
    spi_rdata = 32'h0;
    if (spi_req_addr == c_base + 32'h4)
      spi_rdata = stuck ? 32'h1 : {30'h0, m_rxv, m_busy};
    else if (spi_req_addr == c_base + 32'hC)
      spi_rdata = {24'h0, m_rx};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_busy <= 1'b0; m_rxv <= 1'b0; m_rx <= 8'h0;
      m_rx_next <= 8'h0; m_cnt <= 0; m_idx <= 0; last_ctrl <= 32'h0;
    end else begin
      if (m_pend) begin
        m_pend <= 1'b0; m_busy <= 1'b1; m_cnt <= c_shift;
      end else if (m_busy) begin
        if (m_cnt == 1) begin m_busy <= 1'b0; m_rxv <= 1'b1; m_rx <= m_rx_next; end
        m_cnt <= m_cnt - 1;
      end
      if (spi_req_valid) begin
        n_spi <= n_spi + 1;
        if (spi_req_write && spi_req_addr == c_base) begin
          last_ctrl <= spi_req_wdata;
          if (spi_req_wdata[8]) begin m_idx <= 0; m_rxv <= 1'b0; end
        end
        if (spi_req_write && spi_req_addr == c_base + 32'h8) begin
          mosi_q.push_back(spi_req_wdata[7:0]);
          m_pend    <= 1'b1;
          m_rx_next <= (m_idx < 4) ? 8'hFF : 8'(m_idx + 156);
          m_idx     <= m_idx + 1;
          if (m_busy || m_pend) n_tx_busy <= n_tx_busy + 1;
          if (mem_valid) n_tx_in_mem <= n_tx_in_mem + 1;
        end
        if (!spi_req_write && spi_req_addr == c_base + 32'h4) n_status <= n_status + 1;
        if (!spi_req_write && spi_req_addr == c_base + 32'hC) m_rxv <= 1'b0;
      end
    end
  end

  // ---------------- memory port capture ----------------
  logic [31:0] mem_a_q[$], mem_d_q[$];
  logic [3:0]  mem_s_q[$];
  int n_memv = 0, n_done = 0, n_unstable = 0;
  logic        p_hold = 1'b0;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_strb;

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      mem_a_q.push_back(mem_addr); mem_d_q.push_back(mem_wdata); mem_s_q.push_back(mem_wstrb);
    end
    if (mem_valid) n_memv <= n_memv + 1;
    if (done) n_done <= n_done + 1;
    if (p_hold && (!mem_valid || mem_addr != p_addr || mem_wdata != p_data || mem_wstrb != p_strb))
      n_unstable <= n_unstable + 1;
    p_hold <= mem_valid && !mem_ready;
    p_addr <= mem_addr; p_data <= mem_wdata; p_strb <= mem_wstrb;
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_done"},  32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_spi_valid"}, 32'(spi_req_valid), 32'h0);
    chk({tag, "_spi_write"}, 32'(spi_req_write), 32'h0);
    chk({tag, "_spi_addr"},  spi_req_addr, c_base);
    chk({tag, "_spi_wdata"}, spi_req_wdata, 32'h0);
    chk({tag, "_spi_wstrb"}, 32'(spi_req_wstrb), 32'hF);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'h0);
    chk({tag, "_mem_addr"},  mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
  endtask

  // Starts a job, checks the cycle right after start, waits for done,
  // then steps one more cycle so the engine is back in idle.
  task automatic run_job(input logic [23:0] fa, input logic [31:0] da,
                         input logic [15:0] len, output int cycles);
    cycles = 0;
    flash_addr = fa; dst_addr = da; byte_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'h1);
    chk("error_cleared", 32'(error), 32'h0);
    if (len != 16'd0) begin
      chk("first_ctrl_valid", 32'(spi_req_valid && spi_req_write && spi_req_addr == c_base), 32'h1);
      chk("first_ctrl_wdata", spi_req_wdata, c_ctrl_on);
    end
    while (!done && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("done_seen", 32'(done), 32'h1);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'h0);
  endtask

  function automatic logic [7:0] exp_tx(input int i, input logic [23:0] fa);
    case (i)
      0: return 8'h03;
      1: return fa[23:16];
      2: return fa[15:8];
      3: return fa[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_job(input string tag, input logic [23:0] fa, input logic [31:0] da,
                           input int len, input int mosi0, input int mem0, input int done0);
    int nw;
    int rem;
    logic [31:0] w;
    logic [3:0]  s;
    nw = (len + 3) / 4;
    chk({tag, "_mosi_count"}, 32'(mosi_q.size() - mosi0), 32'(len + 4));
    for (int i = 0; i < len + 4; i++)
      if (mosi0 + i < mosi_q.size())
        chk({tag, "_mosi_byte"}, 32'(mosi_q[mosi0 + i]), 32'(exp_tx(i, fa)));
    chk({tag, "_mem_count"}, 32'(mem_a_q.size() - mem0), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      w = 32'h0; s = 4'h0;
      rem = len - 4 * k;
      for (int b = 0; b < 4; b++)
        if (b < rem) begin
          w[8*b +: 8] = 8'(160 + 4 * k + b);
          s[b] = 1'b1;
        end
      if (mem0 + k < mem_a_q.size()) begin
        chk({tag, "_mem_addr"},  mem_a_q[mem0 + k], {da[31:2], 2'b00} + 32'(4 * k));
        chk({tag, "_mem_data"},  mem_d_q[mem0 + k], w);
        chk({tag, "_mem_strb"},  32'(mem_s_q[mem0 + k]), 32'(s));
      end
    end
    chk({tag, "_done_pulses"}, 32'(n_done - done0), 32'h1);
    chk({tag, "_cs_released"}, last_ctrl, c_ctrl_off);
    chk({tag, "_error"}, 32'(error), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, m0, q0, d0, s0, v0, u0, t0, held, w;

    // Reset state
    #2;
    chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-byte job, two full words
    m0 = mosi_q.size(); q0 = mem_a_q.size(); d0 = n_done; v0 = n_memv; t0 = n_tx_busy;
    run_job(24'h012345, 32'h0000_0100, 16'd8, cyc);
    check_job("len8", 24'h012345, 32'h0000_0100, 8, m0, q0, d0);
    chk("len8_memvalid_cycles", 32'(n_memv - v0), 32'd2);
    chk("len8_no_tx_while_busy", 32'(n_tx_busy - t0), 32'h0);

    // 5-byte job, partial last word; dst low bits are ignored
    m0 = mosi_q.size(); q0 = mem_a_q.size(); d0 = n_done;
    run_job(24'h00ABCD, 32'h0000_0103, 16'd5, cyc);
    check_job("len5", 24'h00ABCD, 32'h0000_0100, 5, m0, q0, d0);

    // Zero-length job: no bus traffic at all
    s0 = n_spi; v0 = n_memv; d0 = n_done;
    run_job(24'h111111, 32'h0000_0500, 16'd0, cyc);
    chk("len0_done_latency_ok", 32'(cyc <= 3), 32'h1);
    chk("len0_spi_traffic", 32'(n_spi - s0), 32'h0);
    chk("len0_mem_traffic", 32'(n_memv - v0), 32'h0);
    chk("len0_done_pulses", 32'(n_done - d0), 32'h1);

    // Memory back-pressure on the first word plus an ignored start while busy
    m0 = mosi_q.size(); q0 = mem_a_q.size(); d0 = n_done; u0 = n_unstable; t0 = n_tx_in_mem;
    held = 0;
    mem_ready = 1'b0;
    fork
      run_job(24'h020304, 32'h0000_0300, 16'd8, cyc);
      begin
        w = 0;
        while (!mem_valid && w < 2000) begin @(posedge clk); #1; w++; end
        chk("stall_mem_valid_seen", 32'(mem_valid), 32'h1);
        flash_addr = 24'hFFFFFF; dst_addr = 32'hDEAD_0000; byte_len = 16'd1; start = 1'b1;
        repeat (20) begin
          @(posedge clk); #1;
          start = 1'b0;
          if (mem_valid) held++;
        end
        mem_ready = 1'b1;
      end
    join
    chk("stall_held_cycles", 32'(held), 32'd20);
    chk("stall_unstable", 32'(n_unstable - u0), 32'h0);
    chk("stall_tx_during_mem", 32'(n_tx_in_mem - t0), 32'h0);
    check_job("stall", 24'h020304, 32'h0000_0300, 8, m0, q0, d0);

    // Poll timeout: STATUS stuck busy
    stuck = 1'b1;
    s0 = n_status; d0 = n_done; q0 = mem_a_q.size();
    run_job(24'h000000, 32'h0000_0400, 16'd4, cyc);
    chk("timeout_error", 32'(error), 32'h1);
    chk("timeout_polls", 32'(n_status - s0), 32'd16);
    chk("timeout_cs_released", last_ctrl, c_ctrl_off);
    chk("timeout_done_pulses", 32'(n_done - d0), 32'h1);
    chk("timeout_no_mem", 32'(mem_a_q.size() - q0), 32'h0);
    stuck = 1'b0;

    // Next start clears error (checked inside run_job) and completes
    m0 = mosi_q.size(); q0 = mem_a_q.size(); d0 = n_done;
    run_job(24'h001000, 32'h0000_0600, 16'd4, cyc);
    check_job("after_timeout", 24'h001000, 32'h0000_0600, 4, m0, q0, d0);

    // Reset during data byte 3
    m0 = mosi_q.size();
    flash_addr = 24'h0A0B0C; dst_addr = 32'h0000_0700; byte_len = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while ((mosi_q.size() - m0) < 7 && w < 2000) begin @(posedge clk); #1; w++; end
    chk("midreset_reached_byte3", 32'((mosi_q.size() - m0) >= 7), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m0 = mosi_q.size(); q0 = mem_a_q.size(); d0 = n_done;
    run_job(24'h000010, 32'h0000_0200, 16'd4, cyc);
    check_job("post_reset", 24'h000010, 32'h0000_0200, 4, m0, q0, d0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
